cpu_mem_bridge: RTL and testbench

CPU_MEM_BRIDGE -- requirements
Module: cpu_mem_bridge

---
 rtl/cpu_mem_bridge.sv | 153 +++++++++++++++
 tb/tb_cpu_mem_bridge.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: connects a CPU fetch port and a load/store port to a single
// synchronous RAM, one request in flight at a time.
//
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   PC, Inst_Req_Valid/Ready          instruction fetch request
//   Instruction, Inst_Valid/Ready     instruction response
//   Address, MemWrite, MemRead,
//   Write_data, Write_strb,
//   Mem_Req_Ready                     data request (data wins arbitration)
//   Read_data, Read_data_Valid/Ready  load response
//   mem_addr, mem_en, mem_wen,
//   mem_wdata, mem_rdata              synchronous RAM port (1-cycle read)
//   perf_req_cnt, perf_stall_cnt      accepted requests / response stall cycles
module cpu_mem_bridge #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       PC,
    input  logic              Inst_Req_Valid,
    output logic              Inst_Req_Ready,
    output logic [31:0]       Instruction,
    output logic              Inst_Valid,
    input  logic              Inst_Ready,
    input  logic [31:0]       Address,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [31:0]       Write_data,
    input  logic [3:0]        Write_strb,
    output logic              Mem_Req_Ready,
    output logic [31:0]       Read_data,
    output logic              Read_data_Valid,
    input  logic              Read_data_Ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic [3:0]        mem_wen,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       perf_req_cnt,
    output logic [31:0]       perf_stall_cnt
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, CAPT, RESP} state_e;
    typedef enum logic [1:0] {KIND_FETCH, KIND_LOAD, KIND_STORE} kind_e;

    state_e              state_q, state_d;
    kind_e               kind_q, kind_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic [DATA_W-1:0]   resp_q, resp_d;
    logic [DATA_W-1:0]   req_cnt_q, req_cnt_d;
    logic [DATA_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic data_req;
    logic resp_ready;
    logic unused_addr_bits;

    assign data_req   = MemRead | MemWrite;
    assign resp_ready = (kind_q == KIND_FETCH) ? Inst_Ready : Read_data_Ready;

    // Byte-offset and out-of-range address bits are dropped (address wraps).
    assign unused_addr_bits = ^{PC, Address};

    // State and request/response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            kind_q      <= KIND_FETCH;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            resp_q      <= '0;
            req_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            resp_q      <= resp_d;
            req_cnt_q   <= req_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state, request capture and counters
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        resp_d      = resp_q;
        req_cnt_d   = req_cnt_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            IDLE: begin
                if (data_req || Inst_Req_Valid) begin
                    // Data port has priority; write+read together counts as a store.
                    addr_d    = data_req ? Address[ADDR_W+1:2] : PC[ADDR_W+1:2];
                    kind_d    = MemWrite ? KIND_STORE : (MemRead ? KIND_LOAD : KIND_FETCH);
                    wdata_d   = Write_data;
                    strb_d    = Write_strb;
                    req_cnt_d = req_cnt_q + DATA_W'(1);
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                state_d = (kind_q == KIND_STORE) ? IDLE : CAPT;
            end
            CAPT: begin
                resp_d  = mem_rdata;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end else begin
                    stall_cnt_d = stall_cnt_q + DATA_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs are held low while reset is asserted.
    assign Mem_Req_Ready  = rst && (state_q == IDLE);
    assign Inst_Req_Ready = rst && (state_q == IDLE) && !data_req;

    assign Inst_Valid      = (state_q == RESP) && (kind_q == KIND_FETCH);
    assign Read_data_Valid = (state_q == RESP) && (kind_q == KIND_LOAD);
    assign Instruction     = resp_q;
    assign Read_data       = resp_q;

    // RAM port; an all-zero-strobe store issues no RAM cycle at all.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_en    = (state_q == ACCESS) && ((kind_q != KIND_STORE) || (strb_q != '0));
    assign mem_wen   = ((state_q == ACCESS) && (kind_q == KIND_STORE)) ? strb_q : '0;

    assign perf_req_cnt   = req_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge with a behavioural synchronous RAM.
module tb_cpu_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic [31:0] Address;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] perf_req_cnt;
    logic [31:0] perf_stall_cnt;

    logic        pl_en;
    logic [15:0] pl_addr;
    logic [31:0] pl_data;
    logic [31:0] mem [0:65535];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu_mem_bridge #(.ADDR_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .PC              (PC),
        .Inst_Req_Valid  (Inst_Req_Valid),
        .Inst_Req_Ready  (Inst_Req_Ready),
        .Instruction     (Instruction),
        .Inst_Valid      (Inst_Valid),
        .Inst_Ready      (Inst_Ready),
        .Address         (Address),
        .MemWrite        (MemWrite),
        .MemRead         (MemRead),
        .Write_data      (Write_data),
        .Write_strb      (Write_strb),
        .Mem_Req_Ready   (Mem_Req_Ready),
        .Read_data       (Read_data),
        .Read_data_Valid (Read_data_Valid),
        .Read_data_Ready (Read_data_Ready),
        .mem_addr        (mem_addr),
        .mem_en          (mem_en),
        .mem_wen         (mem_wen),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .perf_req_cnt    (perf_req_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
    );

    // Synchronous RAM: read data appears the cycle after a read enable.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_en) begin
            if (mem_wen == 4'b0000) begin
                mem_rdata <= mem[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wen[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        PC = '0; Inst_Req_Valid = 1'b0; Inst_Ready = 1'b0;
        Address = '0; MemWrite = 1'b0; MemRead = 1'b0;
        Write_data = '0; Write_strb = '0; Read_data_Ready = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        repeat (2) tick();
        pl_en = 1'b1; pl_addr = 16'd4;  pl_data = 32'h2408_0005;
        tick();
        pl_addr = 16'd16; pl_data = 32'h1122_3344;
        tick();
        pl_en = 1'b0;

        // Reset: requests ignored, everything quiet
        Inst_Req_Valid = 1'b1; MemRead = 1'b1;
        #1;
        check("rst_mem_req_ready", 32'(Mem_Req_Ready), 32'd0);
        check("rst_inst_req_ready", 32'(Inst_Req_Ready), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_wen", 32'(mem_wen), 32'd0);
        check("rst_inst_valid", 32'(Inst_Valid), 32'd0);
        check("rst_rd_valid", 32'(Read_data_Valid), 32'd0);
        check("rst_req_cnt", perf_req_cnt, 32'd0);
        check("rst_stall_cnt", perf_stall_cnt, 32'd0);
        tick();
        Inst_Req_Valid = 1'b0; MemRead = 1'b0;
        rst = 1'b1;
        #1;
        check("idle_mem_req_ready", 32'(Mem_Req_Ready), 32'd1);

        // Fetch PC=0x10, Inst_Ready held high
        PC = 32'h0000_0010; Inst_Req_Valid = 1'b1; Inst_Ready = 1'b1;
        #1;
        check("f1_inst_req_ready", 32'(Inst_Req_Ready), 32'd1);
        tick();
        Inst_Req_Valid = 1'b0;
        #1;
        check("f1_access_en", 32'(mem_en), 32'd1);
        check("f1_access_addr", 32'(mem_addr), 32'd4);
        check("f1_access_wen", 32'(mem_wen), 32'd0);
        check("f1_access_busy", 32'(Mem_Req_Ready), 32'd0);
        check("f1_access_valid", 32'(Inst_Valid), 32'd0);
        check("f1_req_cnt", perf_req_cnt, 32'd1);
        tick();
        check("f1_capt_valid", 32'(Inst_Valid), 32'd0);
        check("f1_capt_en", 32'(mem_en), 32'd0);
        tick();
        check("f1_resp_valid", 32'(Inst_Valid), 32'd1);
        check("f1_resp_inst", Instruction, 32'h2408_0005);
        check("f1_resp_rdata", Read_data, 32'h2408_0005);
        check("f1_resp_rd_valid", 32'(Read_data_Valid), 32'd0);
        tick();
        check("f1_done_valid", 32'(Inst_Valid), 32'd0);
        check("f1_done_idle", 32'(Mem_Req_Ready), 32'd1);
        check("f1_stall_cnt", perf_stall_cnt, 32'd0);

        // Partial store 0xDEADBEEF strb 0011 to 0x40
        Address = 32'h0000_0040; Write_data = 32'hDEAD_BEEF; Write_strb = 4'b0011; MemWrite = 1'b1;
        #1;
        check("st_mem_req_ready", 32'(Mem_Req_Ready), 32'd1);
        check("st_inst_req_ready", 32'(Inst_Req_Ready), 32'd0);
        tick();
        MemWrite = 1'b0;
        #1;
        check("st_en", 32'(mem_en), 32'd1);
        check("st_wen", 32'(mem_wen), 32'b0011);
        check("st_addr", 32'(mem_addr), 32'd16);
        check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        check("st_wen_one_cycle", 32'(mem_wen), 32'd0);
        check("st_idle", 32'(Mem_Req_Ready), 32'd1);
        check("st_req_cnt", perf_req_cnt, 32'd2);

        // Load back 0x40
        MemRead = 1'b1; Read_data_Ready = 1'b1;
        tick();
        MemRead = 1'b0;
        #1;
        check("ld_en", 32'(mem_en), 32'd1);
        check("ld_wen", 32'(mem_wen), 32'd0);
        tick();
        tick();
        check("ld_valid", 32'(Read_data_Valid), 32'd1);
        check("ld_data", Read_data, 32'h1122_BEEF);
        check("ld_inst_valid", 32'(Inst_Valid), 32'd0);
        tick();
        check("ld_done_valid", 32'(Read_data_Valid), 32'd0);
        check("ld_req_cnt", perf_req_cnt, 32'd3);

        // Fetch and load together: load first, then 5 cycles of backpressure
        PC = 32'h0000_0010; Inst_Req_Valid = 1'b1; Inst_Ready = 1'b1;
        Address = 32'h0000_0040; MemRead = 1'b1; Read_data_Ready = 1'b0;
        #1;
        check("arb_mem_req_ready", 32'(Mem_Req_Ready), 32'd1);
        check("arb_inst_req_ready", 32'(Inst_Req_Ready), 32'd0);
        tick();
        MemRead = 1'b0;
        #1;
        check("arb_busy_inst_ready", 32'(Inst_Req_Ready), 32'd0);
        check("arb_load_addr", 32'(mem_addr), 32'd16);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(Read_data_Valid), 32'd1);
            check("bp_data", Read_data, 32'h1122_BEEF);
            check("bp_inst_valid", 32'(Inst_Valid), 32'd0);
            tick();
        end
        check("bp_stall_cnt", perf_stall_cnt, 32'd5);
        check("bp_still_valid", 32'(Read_data_Valid), 32'd1);
        Read_data_Ready = 1'b1;
        tick();
        check("bp_done_valid", 32'(Read_data_Valid), 32'd0);
        check("arb_fetch_ready", 32'(Inst_Req_Ready), 32'd1);
        check("bp_stall_hold", perf_stall_cnt, 32'd5);
        tick();
        Inst_Req_Valid = 1'b0; Read_data_Ready = 1'b0;
        #1;
        check("arb_fetch_addr", 32'(mem_addr), 32'd4);
        check("arb_req_cnt", perf_req_cnt, 32'd5);
        tick();
        tick();
        check("arb_fetch_valid", 32'(Inst_Valid), 32'd1);
        check("arb_fetch_inst", Instruction, 32'h2408_0005);
        tick();
        check("arb_fetch_done", 32'(Inst_Valid), 32'd0);
        check("arb_stall_final", perf_stall_cnt, 32'd5);

        // Zero-strobe store at a wrapping address
        Address = 32'h0004_0000; Write_data = 32'hFFFF_FFFF; Write_strb = 4'b0000; MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
        #1;
        check("z_en", 32'(mem_en), 32'd0);
        check("z_wen", 32'(mem_wen), 32'd0);
        check("z_addr_wrap", 32'(mem_addr), 32'd0);
        check("z_busy", 32'(Mem_Req_Ready), 32'd0);
        tick();
        check("z_idle", 32'(Mem_Req_Ready), 32'd1);
        check("z_req_cnt", perf_req_cnt, 32'd6);

        // Reset while a load sits in CAPT
        Address = 32'h0000_0040; MemRead = 1'b1; Read_data_Ready = 1'b0; Inst_Ready = 1'b0;
        tick();
        MemRead = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("rr_valid", 32'(Read_data_Valid), 32'd0);
        check("rr_req_cnt", perf_req_cnt, 32'd0);
        check("rr_stall_cnt", perf_stall_cnt, 32'd0);
        check("rr_mem_req_ready", 32'(Mem_Req_Ready), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_no_resp", 32'(Read_data_Valid), 32'd0);
            check("rr_idle", 32'(Mem_Req_Ready), 32'd1);
            tick();
        end
        PC = 32'h0000_0010; Inst_Req_Valid = 1'b1; Inst_Ready = 1'b1;
        #1;
        check("rr_fetch_ready", 32'(Inst_Req_Ready), 32'd1);
        tick();
        Inst_Req_Valid = 1'b0;
        tick();
        tick();
        check("rr_fetch_valid", 32'(Inst_Valid), 32'd1);
        check("rr_fetch_inst", Instruction, 32'h2408_0005);
        check("rr_req_cnt_after", perf_req_cnt, 32'd1);
        tick();
        check("rr_fetch_done", 32'(Inst_Valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
